data_mem_handler: RTL and testbench
===================================

Name: data_mem_handler

Overview:
Executes loads and stores between the control stage and the data bus. Inputs are the control stage's read_mem/write_mem/load_byte/store_byte decode outputs, the ALU-computed address and the rs2 store data. The block runs one bus transaction per memory instruction, holds the pipeline with stall until the transaction finishes, and formats the load data for the writeback mux (mem_to_reg path).

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUSY without bus_ack before abort (>=1)
ADDR_W, 32, address width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
read_mem  input  1  load request from control stage
write_mem  input  1  store request from control stage
load_byte  input  1  load is LB; 0 = LW
store_byte  input  1  store is SB; 0 = SW
address  input  ADDR_W  effective address from ALU
store_data  input  32  rs2 value
load_data  output  32  formatted load result to writeback
stall  output  1  hold PC/pipeline registers
done  output  1  one-cycle pulse when transaction ends
bus_err  output  1  one-cycle pulse with done on timeout or misalign trap
bus_req  output  1  bus request, held until ack/abort
bus_we  output  1  1 = write
bus_addr  output  ADDR_W  word-aligned address ({address[ADDR_W-1:2],2'b00})
bus_wdata  output  32  write data
bus_sel  output  4  byte-lane enables
bus_ack  input  1  bus completion, single-cycle
bus_rdata  input  32  read data, valid with bus_ack

Behaviour:
- Reset (async, any state): state=IDLE; load_data=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, bus_sel=0, done=0, bus_err=0, timeout counter=0. An in-flight bus_req drops immediately. A late bus_ack after reset is ignored.
- States: IDLE, BUSY, DONE.
- IDLE: req = read_mem | write_mem. If req is high:
  - latch type, address and data;
  - drive bus_req, bus_we, bus_addr, bus_sel and bus_wdata as registers, valid from the next cycle;
  - go to BUSY.
  If read_mem and write_mem are both high, the write wins.
- Lane rules, lane = address[1:0], little-endian:
  - SW: sel=4'b1111, wdata=store_data.
  - SB: sel=4'b0001<<lane, wdata={4{store_data[7:0]}}.
  - All loads: sel=4'b1111.
- BUSY: bus_req=1 and the counter increments each cycle.
  - On bus_ack: register load_data and go to DONE.
    - LW: load_data = bus_rdata.
    - LB: load_data = sign-extended byte bus_rdata[8*lane+7 : 8*lane].
    - Stores: load_data is unchanged.
  - If no ack and counter==TIMEOUT_CYCLES-1: go to DONE with bus_err set and load_data=0.
  - If ack arrives in the same cycle the timeout would fire, ack wins.
  - bus_req, bus_we, bus_addr, bus_sel and bus_wdata clear on leaving BUSY.
- DONE: done=1 and bus_err as determined in BUSY, for exactly one cycle. Counter clears. Next state is IDLE, and a new request is sampled there.
- stall (combinational) = (IDLE & req) | BUSY. It is low in DONE, so the pipeline advances on the DONE edge.
- Latency: zero-wait ack gives stall high for 2 cycles (IDLE, BUSY) and done in cycle 3.
- load_data holds its value until the next completed load.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: an LW/SW with address[1:0]!=0 issues no bus request. IDLE goes straight to DONE (stall high 1 cycle) with bus_err=1, done=1, load_data=0, and memory is untouched.
- Undefined: the low address bits are ignored for word accesses. The access goes to the aligned word and bus_err fires only on timeout.

Test Plan:
- Reset mid-BUSY: assert rst during a pending read → bus_req=0 and state IDLE the same cycle; all outputs 0; a later bus_ack causes no done.
- LW with 0-wait ack: address=0x100, bus_rdata=0xDEADBEEF → bus_addr=0x100, sel=1111, stall high 2 cycles, done in cycle 3, load_data=0xDEADBEEF.
- LB with 3 wait cycles: address=0x203, bus_rdata=0x80112233 → bus_addr=0x200, stall high 5 cycles, load_data=0xFFFFFF80. Repeat with address=0x201 → load_data=0x00000022.
- SB: address=0x42, store_data=0x000000A5 → bus_we=1, bus_sel=0100, bus_wdata=0xA5A5A5A5. SW: address=0x40 → bus_sel=1111.
- Timeout: TIMEOUT_CYCLES=4, read with no ack → bus_req high 4 cycles, then done=1, bus_err=1, load_data=0. Ack on the 4th cycle → normal completion with bus_err=0.
- MISALIGN_TRAP_EN defined: LW address=0x102 → no bus_req, done and bus_err pulse in cycle 2. Undefined: bus_addr=0x100, normal completion.

Source files
------------

// File: rtl/data_mem_handler.sv
// Load/store bus handler: one bus transaction per memory instruction, stalls the pipeline until done.
// Optional MISALIGN_TRAP_EN: misaligned LW/SW complete immediately with bus_err and no bus request.
module data_mem_handler #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_mem,
  input  logic              write_mem,
  input  logic              load_byte,
  input  logic              store_byte,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              done,
  output logic              bus_err,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [31:0]       bus_wdata,
  output logic [3:0]        bus_sel,
  input  logic              bus_ack,
  input  logic [31:0]       bus_rdata
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_write_q, is_write_d;
  logic               is_byte_q, is_byte_d;
  logic [1:0]         lane_q, lane_d;
  logic               err_q, err_d;
  logic [31:0]        load_data_q, load_data_d;
  logic               bus_req_q, bus_req_d;
  logic               bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]  bus_addr_q, bus_addr_d;
  logic [31:0]        bus_wdata_q, bus_wdata_d;
  logic [3:0]         bus_sel_q, bus_sel_d;

  logic       req;
  logic       req_byte;
  logic       misalign;
  logic       timeout_hit;
  logic [7:0] rd_byte;

  assign req         = read_mem | write_mem;
  // Write wins when both decode outputs are high, so byte-ness follows the store flag.
  assign req_byte    = write_mem ? store_byte : load_byte;
`ifdef MISALIGN_TRAP_EN
  assign misalign    = !req_byte && (address[1:0] != 2'b00);
`else
  assign misalign    = 1'b0;
`endif
  assign timeout_hit = (cnt_q == CNT_LAST);
  assign rd_byte     = bus_rdata[8*lane_q +: 8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req) state_d = misalign ? DONE : BUSY;
      BUSY:    if (bus_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall   = ((state_q == IDLE) && req) || (state_q == BUSY);
    done    = (state_q == DONE);
    bus_err = (state_q == DONE) && err_q;
  end

  always_comb begin
    cnt_d       = cnt_q;
    is_write_d  = is_write_q;
    is_byte_d   = is_byte_q;
    lane_d      = lane_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_sel_d   = bus_sel_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        err_d = 1'b0;
        if (req) begin
          is_write_d = write_mem;
          is_byte_d  = req_byte;
          lane_d     = address[1:0];
          if (misalign) begin
            err_d       = 1'b1;
            load_data_d = '0;
          end else begin
            bus_req_d   = 1'b1;
            bus_we_d    = write_mem;
            bus_addr_d  = {address[ADDR_W-1:2], 2'b00};
            bus_sel_d   = (write_mem && store_byte) ? (4'b0001 << address[1:0]) : 4'b1111;
            bus_wdata_d = (write_mem && store_byte) ? {4{store_data[7:0]}} : store_data;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_ack || timeout_hit) begin
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
          bus_sel_d   = '0;
          if (bus_ack) begin
            err_d = 1'b0;
            if (!is_write_q)
              load_data_d = is_byte_q ? {{24{rd_byte[7]}}, rd_byte} : bus_rdata;
          end else begin
            err_d       = 1'b1;
            load_data_d = '0;
          end
        end
      end
      DONE:    cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      is_write_q  <= 1'b0;
      is_byte_q   <= 1'b0;
      lane_q      <= '0;
      err_q       <= 1'b0;
      load_data_q <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_sel_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      is_write_q  <= is_write_d;
      is_byte_q   <= is_byte_d;
      lane_q      <= lane_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_sel_q   <= bus_sel_d;
    end
  end

  assign load_data = load_data_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_sel   = bus_sel_q;

endmodule

// File: tb/tb_data_mem_handler.sv
// Bench for data_mem_handler: directed scenarios plus randomized transactions against a transaction-level model.
module tb_data_mem_handler;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_mem, write_mem, load_byte, store_byte;
  logic [31:0] address, store_data;
  logic [31:0] load_data;
  logic        stall, done, bus_err, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] exp_ld;

  typedef struct {
    int          stall_n;
    int          done_cyc;
    int          req_n;
    logic        err;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] ld;
  } obs_t;

  always #5 clk = ~clk;

  data_mem_handler #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .read_mem(read_mem), .write_mem(write_mem), .load_byte(load_byte), .store_byte(store_byte),
    .address(address), .store_data(store_data),
    .load_data(load_data), .stall(stall), .done(done), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_sel(bus_sel), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  // Transaction-level expectation: cycle counts, bus fields and resulting load value.
  function automatic obs_t model(input logic rd, wr, lb, sb, input logic [31:0] a, sd,
                                 input int wait_n, input bit give_ack, input logic [31:0] rdv,
                                 input logic [31:0] prev);
    obs_t e;
    int   busy;
    bit   ack_eff, is_byte, trap;
    logic [7:0] b;
    e = '{default: 0};
    is_byte = wr ? sb : lb;
    trap    = 0;
`ifdef MISALIGN_TRAP_EN
    trap = !is_byte && (a % 4 != 0);
`endif
    if (trap) begin
      e.stall_n = 1; e.done_cyc = 2; e.req_n = 0; e.err = 1; e.ld = 0;
      return e;
    end
    ack_eff = give_ack && (wait_n < T);
    busy    = ack_eff ? wait_n + 1 : T;
    e.stall_n  = 1 + busy;
    e.done_cyc = busy + 2;
    e.req_n    = busy;
    e.err      = !ack_eff;
    e.we       = wr;
    e.addr     = a - (a % 4);
    e.sel      = (wr && sb) ? 4'(1 << (a % 4)) : 4'hF;
    e.wdata    = (wr && sb) ? (sd & 32'hFF) * 32'h01010101 : sd;
    b          = 8'((rdv >> (8 * (a % 4))) & 32'hFF);
    if (!ack_eff)  e.ld = 0;
    else if (wr)   e.ld = prev;
    else if (lb)   e.ld = 32'($signed(b));
    else           e.ld = rdv;
    return e;
  endfunction

  task automatic run_txn(input logic rd, wr, lb, sb, input logic [31:0] a, sd,
                         input int wait_n, input bit give_ack, input logic [31:0] rdv,
                         output obs_t o);
    o = '{default: 0};
    @(posedge clk); #1;
    read_mem = rd; write_mem = wr; load_byte = lb; store_byte = sb; address = a; store_data = sd;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (stall) o.stall_n++;
      if (bus_req) begin
        if (o.req_n == 0) begin
          o.we = bus_we; o.addr = bus_addr; o.sel = bus_sel; o.wdata = bus_wdata;
        end
        o.req_n++;
      end
      if (done) begin
        o.done_cyc = cyc; o.err = bus_err; o.ld = load_data;
        break;
      end
      bus_ack   = give_ack && bus_req && (o.req_n - 1 == wait_n);
      bus_rdata = bus_ack ? rdv : $urandom;
    end
    bus_ack = 1'b0;
    @(posedge clk); #1;
    read_mem = 0; write_mem = 0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_checks++;
    if ({load_data, stall, done, bus_err, bus_req, bus_we, bus_addr, bus_wdata, bus_sel} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: ld=%h stall=%b done=%b err=%b req=%b we=%b addr=%h wdata=%h sel=%b, want all 0",
               load_data, stall, done, bus_err, bus_req, bus_we, bus_addr, bus_wdata, bus_sel);
    end
    rst = 1'b0;
    exp_ld = '0;
  endtask

  task automatic test_reset_mid_busy;
    bit saw;
    @(posedge clk); #1;
    read_mem = 1; load_byte = 0; address = 32'h300;
    @(posedge clk); #1;
    n_checks++;
    if (bus_req !== 1'b1) begin n_err++; $display("FAIL rst_busy_pre_req: got %b want 1", bus_req); end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus_req, bus_addr, bus_sel, done, bus_err, load_data} !== '0) begin
      n_err++;
      $display("FAIL rst_busy_outputs: req=%b addr=%h sel=%b done=%b err=%b ld=%h want 0",
               bus_req, bus_addr, bus_sel, done, bus_err, load_data);
    end
    read_mem = 0;
    #1;
    n_checks++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL rst_busy_stall: got %b want 0", stall); end
    @(negedge clk); rst = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(negedge clk); bus_ack = 1'b0;
    saw = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || bus_req || stall) saw = 1;
      @(negedge clk);
    end
    n_checks++;
    if (saw) begin n_err++; $display("FAIL rst_late_ack: got activity=1 want 0"); end
    exp_ld = '0;
  endtask

  task automatic test_lw;
    obs_t o;
    run_txn(1, 0, 0, 0, 32'h100, 32'h0, 0, 1, 32'hDEADBEEF, o);
    n_checks++; if (o.addr !== 32'h100) begin n_err++; $display("FAIL lw_addr: got %h want 00000100", o.addr); end
    n_checks++; if (o.sel !== 4'b1111) begin n_err++; $display("FAIL lw_sel: got %b want 1111", o.sel); end
    n_checks++; if (o.stall_n != 2) begin n_err++; $display("FAIL lw_stall: got %0d want 2", o.stall_n); end
    n_checks++; if (o.done_cyc != 3) begin n_err++; $display("FAIL lw_done_cycle: got %0d want 3", o.done_cyc); end
    n_checks++; if (o.ld !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data: got %h want deadbeef", o.ld); end
    exp_ld = 32'hDEADBEEF;
  endtask

  task automatic test_lb;
    obs_t o;
    run_txn(1, 0, 1, 0, 32'h203, 32'h0, 3, 1, 32'h80112233, o);
    n_checks++; if (o.addr !== 32'h200) begin n_err++; $display("FAIL lb3_addr: got %h want 00000200", o.addr); end
    n_checks++; if (o.stall_n != 5) begin n_err++; $display("FAIL lb3_stall: got %0d want 5", o.stall_n); end
    n_checks++; if (o.ld !== 32'hFFFFFF80) begin n_err++; $display("FAIL lb3_data: got %h want ffffff80", o.ld); end
    n_checks++; if (o.err !== 1'b0) begin n_err++; $display("FAIL lb3_err: got %b want 0", o.err); end
    run_txn(1, 0, 1, 0, 32'h201, 32'h0, 3, 1, 32'h80112233, o);
    n_checks++; if (o.ld !== 32'h00000022) begin n_err++; $display("FAIL lb1_data: got %h want 00000022", o.ld); end
    exp_ld = 32'h00000022;
  endtask

  task automatic test_stores;
    obs_t o;
    run_txn(0, 1, 0, 1, 32'h42, 32'h000000A5, 1, 1, 32'h12345678, o);
    n_checks++; if (o.we !== 1'b1) begin n_err++; $display("FAIL sb_we: got %b want 1", o.we); end
    n_checks++; if (o.sel !== 4'b0100) begin n_err++; $display("FAIL sb_sel: got %b want 0100", o.sel); end
    n_checks++; if (o.wdata !== 32'hA5A5A5A5) begin n_err++; $display("FAIL sb_wdata: got %h want a5a5a5a5", o.wdata); end
    n_checks++; if (o.ld !== exp_ld) begin n_err++; $display("FAIL sb_ld_hold: got %h want %h", o.ld, exp_ld); end
    run_txn(0, 1, 0, 0, 32'h40, 32'h13579BDF, 0, 1, 32'h0, o);
    n_checks++; if (o.sel !== 4'b1111) begin n_err++; $display("FAIL sw_sel: got %b want 1111", o.sel); end
    n_checks++; if (o.wdata !== 32'h13579BDF) begin n_err++; $display("FAIL sw_wdata: got %h want 13579bdf", o.wdata); end
    run_txn(1, 1, 1, 0, 32'h48, 32'h11223344, 0, 1, 32'h0, o);
    n_checks++; if (o.we !== 1'b1) begin n_err++; $display("FAIL both_we: got %b want 1", o.we); end
  endtask

  task automatic test_timeout;
    obs_t o;
    run_txn(1, 0, 0, 0, 32'h500, 32'h0, 0, 0, 32'h0, o);
    n_checks++; if (o.req_n != T) begin n_err++; $display("FAIL to_req_cycles: got %0d want %0d", o.req_n, T); end
    n_checks++; if (o.done_cyc != T + 2) begin n_err++; $display("FAIL to_done_cycle: got %0d want %0d", o.done_cyc, T + 2); end
    n_checks++; if (o.err !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", o.err); end
    n_checks++; if (o.ld !== 32'h0) begin n_err++; $display("FAIL to_data: got %h want 0", o.ld); end
    run_txn(1, 0, 0, 0, 32'h504, 32'h0, T - 1, 1, 32'h5A5A0F0F, o);
    n_checks++; if (o.err !== 1'b0) begin n_err++; $display("FAIL to_lastack_err: got %b want 0", o.err); end
    n_checks++; if (o.ld !== 32'h5A5A0F0F) begin n_err++; $display("FAIL to_lastack_data: got %h want 5a5a0f0f", o.ld); end
    exp_ld = 32'h5A5A0F0F;
  endtask

  task automatic test_misalign;
    obs_t o;
    run_txn(1, 0, 0, 0, 32'h102, 32'h0, 0, 1, 32'h12345678, o);
`ifdef MISALIGN_TRAP_EN
    n_checks++; if (o.req_n != 0) begin n_err++; $display("FAIL mis_req: got %0d want 0", o.req_n); end
    n_checks++; if (o.done_cyc != 2) begin n_err++; $display("FAIL mis_done_cycle: got %0d want 2", o.done_cyc); end
    n_checks++; if (o.err !== 1'b1) begin n_err++; $display("FAIL mis_err: got %b want 1", o.err); end
    n_checks++; if (o.ld !== 32'h0) begin n_err++; $display("FAIL mis_data: got %h want 0", o.ld); end
    exp_ld = 32'h0;
`else
    n_checks++; if (o.addr !== 32'h100) begin n_err++; $display("FAIL mis_addr: got %h want 00000100", o.addr); end
    n_checks++; if (o.err !== 1'b0) begin n_err++; $display("FAIL mis_err: got %b want 0", o.err); end
    n_checks++; if (o.ld !== 32'h12345678) begin n_err++; $display("FAIL mis_data: got %h want 12345678", o.ld); end
    exp_ld = 32'h12345678;
`endif
  endtask

  task automatic test_random;
    obs_t o, e;
    logic rd, wr, lb, sb;
    logic [31:0] a, sd, rdv;
    int w;
    bit ga;
    for (int n = 0; n < 40; n++) begin
      rd = 0; wr = 0; lb = 0; sb = 0;
      case ($urandom_range(0, 4))
        0: rd = 1;
        1: begin rd = 1; lb = 1; end
        2: wr = 1;
        3: begin wr = 1; sb = 1; end
        default: begin rd = 1; wr = 1; lb = 1'($urandom); sb = 1'($urandom); end
      endcase
      a = $urandom; sd = $urandom; rdv = $urandom;
      w = $urandom_range(0, 4);
      ga = ($urandom_range(0, 4) != 0);
      e = model(rd, wr, lb, sb, a, sd, w, ga, rdv, exp_ld);
      run_txn(rd, wr, lb, sb, a, sd, w, ga, rdv, o);
      n_checks++;
      if (o.stall_n != e.stall_n || o.done_cyc != e.done_cyc || o.req_n != e.req_n) begin
        n_err++;
        $display("FAIL rnd%0d_timing: stall/done/req got %0d/%0d/%0d want %0d/%0d/%0d",
                 n, o.stall_n, o.done_cyc, o.req_n, e.stall_n, e.done_cyc, e.req_n);
      end
      n_checks++;
      if (o.err !== e.err || o.ld !== e.ld) begin
        n_err++;
        $display("FAIL rnd%0d_result: err/ld got %b/%h want %b/%h", n, o.err, o.ld, e.err, e.ld);
      end
      if (e.req_n > 0) begin
        n_checks++;
        if (o.we !== e.we || o.addr !== e.addr || o.sel !== e.sel || (e.we && o.wdata !== e.wdata)) begin
          n_err++;
          $display("FAIL rnd%0d_bus: we/addr/sel/wdata got %b/%h/%b/%h want %b/%h/%b/%h",
                   n, o.we, o.addr, o.sel, o.wdata, e.we, e.addr, e.sel, e.wdata);
        end
      end
      exp_ld = e.ld;
    end
  endtask

  initial begin
    rst = 1'b1;
    read_mem = 0; write_mem = 0; load_byte = 0; store_byte = 0;
    address = '0; store_data = '0; bus_ack = 0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    test_reset;
    test_lw;
    test_lb;
    test_stores;
    test_timeout;
    test_misalign;
    test_reset_mid_busy;
    test_random;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
